// File: rtl/bresenham_line_engine.sv
// Integer Bresenham line rasterizer: latches one line request, then streams one
// pixel per accepted cycle over valid/ready. Optional pixel counter: BRESENHAM_PIXCNT_EN.
module bresenham_line_engine #(
    parameter int COORD_W = 8
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               draw_en,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic               pix_ready,
    output logic               pix_valid,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
`ifdef BRESENHAM_PIXCNT_EN
    output logic [COORD_W:0]   pix_cnt,
`endif
    output logic               draw_done,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PLOT      = 2'd1,
        DONE      = 2'd2,
        DONE_WAIT = 2'd3
    } state_t;

    localparam logic [COORD_W-1:0] ONE = {{(COORD_W-1){1'b0}}, 1'b1};

    state_t                    state_q, state_d;
    logic [COORD_W-1:0]        x_cur_q, x_cur_d, y_cur_q, y_cur_d;
    logic [COORD_W-1:0]        xe_q, xe_d, ye_q, ye_d, dx_q, dx_d;
    logic signed [COORD_W:0]   dy_q, dy_d;
    logic signed [COORD_W+1:0] err_q, err_d;
    logic                      x_inc_q, x_inc_d, y_inc_q, y_inc_d;
`ifdef BRESENHAM_PIXCNT_EN
    logic [COORD_W:0]          cnt_q, cnt_d;
`endif

    logic [COORD_W-1:0]        adx_s, ady_s;
    logic signed [COORD_W:0]   dy_new_s;
    logic signed [COORD_W+2:0] e2_s, dy3_s, dx3_s;
    logic signed [COORD_W+1:0] dy2_s, dx2_s, err_x_s, err_y_s;
    logic                      step_x_s, step_y_s, at_end_s;

    // Request-time deltas and per-step error comparisons, all sign-extended explicitly
    always_comb begin
        adx_s    = (x1 >= x0) ? (x1 - x0) : (x0 - x1);
        ady_s    = (y1 >= y0) ? (y1 - y0) : (y0 - y1);
        dy_new_s = -$signed({1'b0, ady_s});
        e2_s     = $signed({err_q, 1'b0});
        dy3_s    = $signed({{2{dy_q[COORD_W]}}, dy_q});
        dx3_s    = $signed({3'b000, dx_q});
        dy2_s    = $signed({dy_q[COORD_W], dy_q});
        dx2_s    = $signed({2'b00, dx_q});
        step_x_s = (e2_s >= dy3_s);
        step_y_s = (e2_s <= dx3_s);
        at_end_s = (x_cur_q == xe_q) && (y_cur_q == ye_q);
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        x_cur_d = x_cur_q;
        y_cur_d = y_cur_q;
        xe_d    = xe_q;
        ye_d    = ye_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        err_d   = err_q;
        x_inc_d = x_inc_q;
        y_inc_d = y_inc_q;
        err_x_s = {(COORD_W+2){1'b0}};
        err_y_s = {(COORD_W+2){1'b0}};
`ifdef BRESENHAM_PIXCNT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (draw_en) begin
                    x_cur_d = x0;
                    y_cur_d = y0;
                    xe_d    = x1;
                    ye_d    = y1;
                    dx_d    = adx_s;
                    dy_d    = dy_new_s;
                    x_inc_d = (x0 < x1);
                    y_inc_d = (y0 < y1);
                    err_d   = $signed({2'b00, adx_s}) + $signed({dy_new_s[COORD_W], dy_new_s});
`ifdef BRESENHAM_PIXCNT_EN
                    cnt_d   = {(COORD_W+1){1'b0}};
`endif
                    state_d = PLOT;
                end else begin
                    state_d = IDLE;
                end
            end
            PLOT: begin
                // Abort wins over a simultaneous handshake; that pixel is not counted
                if (!draw_en) begin
                    state_d = IDLE;
                end else if (pix_ready) begin
`ifdef BRESENHAM_PIXCNT_EN
                    cnt_d = cnt_q + {{COORD_W{1'b0}}, 1'b1};
`endif
                    if (at_end_s) begin
                        state_d = DONE;
                    end else begin
                        if (step_x_s) begin
                            err_x_s = dy2_s;
                            x_cur_d = x_inc_q ? (x_cur_q + ONE) : (x_cur_q - ONE);
                        end else begin
                            x_cur_d = x_cur_q;
                        end
                        if (step_y_s) begin
                            err_y_s = dx2_s;
                            y_cur_d = y_inc_q ? (y_cur_q + ONE) : (y_cur_q - ONE);
                        end else begin
                            y_cur_d = y_cur_q;
                        end
                        err_d = err_q + err_x_s + err_y_s;
                    end
                end else begin
                    state_d = PLOT;
                end
            end
            DONE: begin
                state_d = draw_en ? DONE_WAIT : IDLE;
            end
            DONE_WAIT: begin
                state_d = draw_en ? DONE_WAIT : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            x_cur_q <= {COORD_W{1'b0}};
            y_cur_q <= {COORD_W{1'b0}};
            xe_q    <= {COORD_W{1'b0}};
            ye_q    <= {COORD_W{1'b0}};
            dx_q    <= {COORD_W{1'b0}};
            dy_q    <= {(COORD_W+1){1'b0}};
            err_q   <= {(COORD_W+2){1'b0}};
            x_inc_q <= 1'b0;
            y_inc_q <= 1'b0;
`ifdef BRESENHAM_PIXCNT_EN
            cnt_q   <= {(COORD_W+1){1'b0}};
`endif
        end else begin
            state_q <= state_d;
            x_cur_q <= x_cur_d;
            y_cur_q <= y_cur_d;
            xe_q    <= xe_d;
            ye_q    <= ye_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            err_q   <= err_d;
            x_inc_q <= x_inc_d;
            y_inc_q <= y_inc_d;
`ifdef BRESENHAM_PIXCNT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign pix_valid = (state_q == PLOT);
    assign pix_x     = pix_valid ? x_cur_q : {COORD_W{1'b0}};
    assign pix_y     = pix_valid ? y_cur_q : {COORD_W{1'b0}};
    assign draw_done = (state_q == DONE);
    assign busy      = (state_q != IDLE);
`ifdef BRESENHAM_PIXCNT_EN
    assign pix_cnt   = cnt_q;
`endif

endmodule

// File: tb/tb_bresenham_line_engine.sv
// Self-checking bench for bresenham_line_engine: directed lines plus random lines and
// random backpressure, compared against a plain-integer Bresenham pixel list.
module tb_bresenham_line_engine;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       draw_en;
    logic [7:0] x0, y0, x1, y1;
    logic       pix_ready;
    logic       pix_valid;
    logic [7:0] pix_x, pix_y;
    logic       draw_done;
    logic       busy;
`ifdef BRESENHAM_PIXCNT_EN
    logic [8:0] pix_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int exp_x[$];
    int exp_y[$];
    int bp_pat[6] = '{1, 0, 0, 1, 0, 1};

    bresenham_line_engine #(.COORD_W(8)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .draw_en   (draw_en),
        .x0        (x0),
        .y0        (y0),
        .x1        (x1),
        .y1        (y1),
        .pix_ready (pix_ready),
        .pix_valid (pix_valid),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
`ifdef BRESENHAM_PIXCNT_EN
        .pix_cnt   (pix_cnt),
`endif
        .draw_done (draw_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference pixel list from the textbook integer algorithm
    task automatic model(input int ax0, input int ay0, input int ax1, input int ay1);
        int x, y, dx, dy, sx, sy, err, e2;
        exp_x.delete();
        exp_y.delete();
        x   = ax0;
        y   = ay0;
        dx  = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
        dy  = -((ay1 > ay0) ? ay1 - ay0 : ay0 - ay1);
        sx  = (ax0 < ax1) ? 1 : -1;
        sy  = (ay0 < ay1) ? 1 : -1;
        err = dx + dy;
        for (int k = 0; k < 1024; k++) begin
            exp_x.push_back(x);
            exp_y.push_back(y);
            if (x == ax1 && y == ay1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin
                err += dy;
                x   += sx;
            end
            if (e2 <= dx) begin
                err += dx;
                y   += sy;
            end
        end
    endtask

    // mode 0: always ready, 1: random ready, 2: fixed pattern; hold keeps draw_en after done
    task automatic run_line(input string tag, input int ax0, input int ay0, input int ax1,
                            input int ay1, input int mode, input bit hold, input bit scramble);
        int idx, cyc, n, r;
        model(ax0, ay0, ax1, ay1);
        n = exp_x.size();
        @(negedge clk);
        x0 = 8'(ax0);
        y0 = 8'(ay0);
        x1 = 8'(ax1);
        y1 = 8'(ay1);
        pix_ready = 1'b0;
        draw_en = 1'b1;
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 4 * n + 20) begin
            @(negedge clk);
            cyc++;
            if (scramble) begin
                x0 = 8'($urandom_range(0, 255));
                y0 = 8'($urandom_range(0, 255));
                x1 = 8'($urandom_range(0, 255));
                y1 = 8'($urandom_range(0, 255));
            end
            chk({tag, "_pix"}, {15'd0, draw_done, pix_valid, pix_x, pix_y},
                {15'd0, 1'b0, 1'b1, 8'(exp_x[idx]), 8'(exp_y[idx])});
            if (mode == 0) r = 1;
            else if (mode == 1) r = int'($urandom_range(0, 1));
            else r = bp_pat[(cyc - 1) % 6];
            pix_ready = (r != 0);
            if (r != 0 && pix_valid === 1'b1) idx++;
        end
        chk({tag, "_in_budget"}, idx, n);
        @(negedge clk);
        pix_ready = 1'b0;
        chk({tag, "_done"}, {draw_done, pix_valid, busy, pix_x, pix_y}, {3'b101, 16'd0});
`ifdef BRESENHAM_PIXCNT_EN
        chk({tag, "_cnt"}, pix_cnt, n);
`endif
        if (hold) begin
            @(negedge clk);
            chk({tag, "_wait"}, {draw_done, busy, pix_valid}, 3'b010);
            @(negedge clk);
            chk({tag, "_no_retrig"}, {draw_done, busy, pix_valid}, 3'b010);
        end
        draw_en = 1'b0;
        @(negedge clk);
        chk({tag, "_idle"}, {draw_done, busy, pix_valid}, 3'b000);
`ifdef BRESENHAM_PIXCNT_EN
        chk({tag, "_cnt_hold"}, pix_cnt, n);
`endif
    endtask

    initial begin
        n_rst = 1'b0;
        draw_en = 1'b0;
        pix_ready = 1'b0;
        x0 = 8'd0;
        y0 = 8'd0;
        x1 = 8'd0;
        y1 = 8'd0;
        @(negedge clk);
        chk("reset_state", {pix_valid, pix_x, pix_y, draw_done, busy}, 19'd0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", {pix_valid, draw_done, busy}, 3'b000);
`ifdef BRESENHAM_PIXCNT_EN
        chk("reset_cnt", pix_cnt, 0);
`endif

        run_line("horiz",    0,   0,   3,   0, 0, 1'b0, 1'b0);
        run_line("steep",    2,   4,   0,   0, 0, 1'b0, 1'b0);
        run_line("point",    5,   5,   5,   5, 0, 1'b1, 1'b0);
        run_line("bp",       0,   0,   2,   1, 2, 1'b0, 1'b0);
        run_line("diag",     0,   0, 255, 255, 0, 1'b0, 1'b0);
        run_line("diag_rev", 255, 0,   0,   0, 0, 1'b0, 1'b0);
        run_line("latch",   10,  20,  30,   5, 1, 1'b0, 1'b1);

        // Abort after two accepted pixels of (0,0)->(9,0)
        @(negedge clk);
        x0 = 8'd0; y0 = 8'd0; x1 = 8'd9; y1 = 8'd0;
        pix_ready = 1'b1;
        draw_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_pix", {pix_valid, pix_x, pix_y}, {1'b1, 8'(i), 8'd0});
        end
        draw_en = 1'b0;
        @(negedge clk);
        chk("abort_idle", {draw_done, busy, pix_valid}, 3'b000);
`ifdef BRESENHAM_PIXCNT_EN
        chk("abort_cnt", pix_cnt, 2);
`endif
        @(negedge clk);
        chk("abort_no_done", {draw_done, busy}, 2'b00);

        // Asynchronous reset in the middle of (0,0)->(9,9)
        x1 = 8'd9; y1 = 8'd9;
        draw_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", {busy, pix_valid}, 2'b11);
        n_rst = 1'b0;
        #1;
        chk("mid_rst", {pix_valid, pix_x, pix_y, draw_done, busy}, 19'd0);
        draw_en = 1'b0;
        pix_ready = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        chk("after_rst_idle", {pix_valid, busy, draw_done}, 3'b000);

        for (int i = 0; i < 12; i++) begin
            run_line("rnd", int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                     1, (i % 3) == 0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
